// File: rtl/data_mem_io.sv
// data_mem_io: memory-side responder for the core's data-memory port.
// Addresses below IO_BASE hit a data RAM; IO_BASE..IO_BASE+5 hit I/O registers
// (GPIO out, synchronized GPIO in, prescaled 8-bit timer with compare/match/irq).
// Reads are combinational from mem_addr; writes land on the posedge with mem_WE=1.
//
// Ports:
//   clk        clock
//   arst       synchronous, active-high reset
//   mem_addr   address from the core
//   mem_WE     one-cycle write strobe
//   mem_wdata  write data
//   mem_rdata  combinational read data
//   gpio_in    asynchronous external inputs
//   gpio_out   GPIO_OUT register
//   timer_irq  STATUS.match & CTRL.irq_en
module data_mem_io #(
    parameter int unsigned                MEM_ADDR_WIDTH = 8,
    parameter int unsigned                MEM_DATA_WIDTH = 8,
    parameter logic [MEM_ADDR_WIDTH-1:0]  IO_BASE        = 8'hF0,
    parameter int unsigned                PRESCALE       = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic                      mem_WE,
    input  logic [MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic [MEM_DATA_WIDTH-1:0] mem_rdata,
    input  logic [MEM_DATA_WIDTH-1:0] gpio_in,
    output logic [MEM_DATA_WIDTH-1:0] gpio_out,
    output logic                      timer_irq
);

    localparam int unsigned AW        = MEM_ADDR_WIDTH;
    localparam int unsigned DW        = MEM_DATA_WIDTH;
    localparam int unsigned RAM_DEPTH = 32'(IO_BASE);
    localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [AW-1:0] OFF_GPIO_OUT = AW'(0);
    localparam logic [AW-1:0] OFF_GPIO_IN  = AW'(1);
    localparam logic [AW-1:0] OFF_CNT      = AW'(2);
    localparam logic [AW-1:0] OFF_CTRL     = AW'(3);
    localparam logic [AW-1:0] OFF_CMP      = AW'(4);
    localparam logic [AW-1:0] OFF_STATUS   = AW'(5);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    // CTRL bit positions
    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_AR  = 1;
    localparam int unsigned CTRL_IRQ = 2;

    logic [DW-1:0] ram_q [RAM_DEPTH];

    logic [DW-1:0] gpio_out_q, gpio_out_d;
    logic [DW-1:0] sync1_q, sync2_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] cmp_q, cmp_d;
    logic          match_q, match_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          io_sel;
    logic [AW-1:0] io_off;
    logic          wr_ram, wr_gpio, wr_cnt, wr_ctrl, wr_cmp, wr_status;
    logic          tick;
    logic          cnt_hit;

    // Address decode
    assign io_sel    = (mem_addr >= IO_BASE);
    assign io_off    = mem_addr - IO_BASE;
    assign wr_ram    = mem_WE & ~io_sel;
    assign wr_gpio   = mem_WE & io_sel & (io_off == OFF_GPIO_OUT);
    assign wr_cnt    = mem_WE & io_sel & (io_off == OFF_CNT);
    assign wr_ctrl   = mem_WE & io_sel & (io_off == OFF_CTRL);
    assign wr_cmp    = mem_WE & io_sel & (io_off == OFF_CMP);
    assign wr_status = mem_WE & io_sel & (io_off == OFF_STATUS);

    assign tick    = ctrl_q[CTRL_EN] & (presc_q == PRESC_LAST);
    assign cnt_hit = (cnt_q == cmp_q);

    // Data RAM: no reset, contents survive arst
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[mem_addr] <= mem_wdata;
        end
    end

    // Combinational read mux
    always_comb begin
        mem_rdata = '0;
        if (!io_sel) begin
            mem_rdata = ram_q[mem_addr];
        end else begin
            case (io_off)
                OFF_GPIO_OUT: mem_rdata = gpio_out_q;
                OFF_GPIO_IN:  mem_rdata = sync2_q;
                OFF_CNT:      mem_rdata = cnt_q;
                OFF_CTRL:     mem_rdata = DW'(ctrl_q);
                OFF_CMP:      mem_rdata = cmp_q;
                OFF_STATUS:   mem_rdata = DW'(match_q);
                default:      mem_rdata = '0;
            endcase
        end
    end

    // Register next-state: bus writes and timer
    always_comb begin
        gpio_out_d = gpio_out_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        cmp_d      = cmp_q;
        match_d    = match_q;
        presc_d    = presc_q;

        if (wr_gpio) gpio_out_d = mem_wdata;
        if (wr_ctrl) ctrl_d     = mem_wdata[2:0];
        if (wr_cmp)  cmp_d      = mem_wdata;

        // Prescaler: any CNT write restarts it; otherwise it wraps on tick
        if (wr_cnt || tick) begin
            presc_d = '0;
        end else if (ctrl_q[CTRL_EN]) begin
            presc_d = presc_q + PW'(1);
        end

        // A CNT write overrides the tick; compare always uses the old CMP
        if (wr_cnt) begin
            cnt_d = mem_wdata;
        end else if (tick) begin
            if (cnt_hit && ctrl_q[CTRL_AR]) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end

        // W1C first so a simultaneous match set wins
        if (wr_status && mem_wdata[0]) match_d = 1'b0;
        if (tick && !wr_cnt && cnt_hit) match_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (arst) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            cmp_q      <= '0;
            match_q    <= 1'b0;
            presc_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            presc_q    <= presc_d;
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = match_q & ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: directed literal sequences followed by randomized
// traffic, all compared against a behavioural model of the register map.
module tb_data_mem_io;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int IO_BASE  = 'hF0;
    localparam int PRESCALE = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW-1:0] mem_addr;
    logic          mem_WE;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] gpio_in;
    logic [DW-1:0] gpio_out;
    logic          timer_irq;

    always #5 clk = ~clk;

    data_mem_io #(
        .MEM_ADDR_WIDTH(AW),
        .MEM_DATA_WIDTH(DW),
        .IO_BASE       (8'hF0),
        .PRESCALE      (PRESCALE)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .mem_addr (mem_addr),
        .mem_WE   (mem_WE),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .timer_irq(timer_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    int m_ram [256];
    bit m_valid [256];
    int m_gpio_out, m_cnt, m_ctrl, m_cmp, m_match;
    int m_en_clocks;      // enabled clocks since the timer last restarted
    int m_seen [2];       // gpio_in as seen one and two edges ago
    bit m_tick, m_set_match;
    int m_a, m_wd, m_off;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic int model_read(input int a);
        if (a < IO_BASE) return m_ram[a];
        case (a - IO_BASE)
            0: return m_gpio_out;
            1: return m_seen[1];
            2: return m_cnt;
            3: return m_ctrl;
            4: return m_cmp;
            5: return m_match;
            default: return 0;
        endcase
    endfunction

    // Model update at each active edge
    always @(posedge clk) begin
        m_a  = int'(mem_addr);
        m_wd = int'(mem_wdata);
        m_off = m_a - IO_BASE;
        if (mem_WE && m_a < IO_BASE) begin
            m_ram[m_a]   = m_wd;
            m_valid[m_a] = 1'b1;
        end
        if (arst) begin
            m_gpio_out  = 0;
            m_cnt       = 0;
            m_ctrl      = 0;
            m_cmp       = 0;
            m_match     = 0;
            m_en_clocks = 0;
            m_seen[0]   = 0;
            m_seen[1]   = 0;
        end else begin
            m_seen[1] = m_seen[0];
            m_seen[0] = int'(gpio_in);
            m_tick      = 1'b0;
            m_set_match = 1'b0;
            if ((m_ctrl & 1) != 0) begin
                m_en_clocks++;
                if (m_en_clocks == PRESCALE) begin
                    m_tick      = 1'b1;
                    m_en_clocks = 0;
                end
            end
            if (mem_WE && m_off == 2) begin
                m_cnt       = m_wd;
                m_en_clocks = 0;
            end else if (m_tick) begin
                if (m_cnt == m_cmp) begin
                    m_set_match = 1'b1;
                    m_cnt = ((m_ctrl & 2) != 0) ? 0 : (m_cnt + 1) % 256;
                end else begin
                    m_cnt = (m_cnt + 1) % 256;
                end
            end
            if (mem_WE) begin
                case (m_off)
                    0: m_gpio_out = m_wd;
                    3: m_ctrl     = m_wd & 7;
                    4: m_cmp      = m_wd;
                    5: if ((m_wd & 1) != 0) m_match = 0;
                    default: ;
                endcase
            end
            if (m_set_match) m_match = 1;
        end
    end

    // Compare process: outputs against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("gpio_out", 32'(gpio_out), 32'(m_gpio_out));
            check("timer_irq", 32'(timer_irq), 32'((m_match != 0) && ((m_ctrl & 4) != 0)));
            if (int'(mem_addr) >= IO_BASE || m_valid[int'(mem_addr)])
                check("rdata", 32'(mem_rdata), 32'(model_read(int'(mem_addr))));
        end
    end

    task automatic drive(input int a, input bit we, input int wd, input bit rst = 1'b0);
        @(posedge clk);
        #1;
        mem_addr  = AW'(a);
        mem_WE    = we;
        mem_wdata = DW'(wd);
        arst      = rst;
    endtask

    task automatic read_chk(input string name, input int a, input int exp);
        drive(a, 1'b0, 0);
        @(negedge clk);
        check(name, 32'(mem_rdata), 32'(exp));
    endtask

    int e;
    int a;

    initial begin
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        arst      = 1'b1;
        mem_addr  = '0;
        mem_WE    = 1'b0;
        mem_wdata = '0;
        gpio_in   = '0;
        repeat (3) @(posedge clk);
        drive(0, 1'b0, 0);
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        read_chk("rst_cnt", 'hF2, 0);
        read_chk("rst_ctrl", 'hF3, 0);
        read_chk("rst_cmp", 'hF4, 0);
        read_chk("rst_status", 'hF5, 0);

        // RAM write / read back
        drive('h10, 1'b1, 'h5A);
        drive('h11, 1'b1, 'hA5);
        read_chk("ram_10", 'h10, 'h5A);
        read_chk("ram_11", 'h11, 'hA5);
        drive('hEF, 1'b1, 'hC3);
        read_chk("ram_ef", 'hEF, 'hC3);

        // GPIO out and ignored writes
        drive('hF0, 1'b1, 'h3C);
        drive('hF1, 1'b0, 0);
        @(negedge clk);
        check("gpio_out_3c", 32'(gpio_out), 32'h3C);
        drive('hF1, 1'b1, 'h55);
        drive('hF8, 1'b1, 'h77);
        read_chk("read_f8", 'hF8, 0);
        check("gpio_out_hold", 32'(gpio_out), 32'h3C);
        read_chk("gpio_in_ro", 'hF1, 0);

        // GPIO input synchronizer latency
        drive('hF1, 1'b0, 0);
        gpio_in = 8'h81;
        @(negedge clk);
        check("gpio_in_n", 32'(mem_rdata), 32'h00);
        read_chk("gpio_in_n1", 'hF1, 'h00);
        read_chk("gpio_in_n2", 'hF1, 'h81);

        // Timer: CMP=3, autoreload + irq
        drive('hF4, 1'b1, 3);
        drive('hF2, 1'b1, 0);
        drive('hF3, 1'b1, 7);
        for (int k = 1; k <= 17; k++) begin
            drive('hF2, 1'b0, 0);
            @(negedge clk);
            check("t4_cnt", 32'(mem_rdata), 32'((k <= 16) ? (k - 1) / 4 : 0));
            check("t4_irq", 32'(timer_irq), 32'(k == 17));
        end
        drive('hF5, 1'b1, 1);
        read_chk("t4_status_clr", 'hF5, 0);
        check("t4_irq_clr", 32'(timer_irq), 32'h0);

        // W1C colliding with match tick, then CNT write on a tick
        drive('hF3, 1'b1, 0);
        drive('hF5, 1'b1, 1);
        drive('hF2, 1'b1, 3);
        drive('hF3, 1'b1, 7);
        repeat (3) drive('hF2, 1'b0, 0);
        drive('hF5, 1'b1, 1);
        read_chk("t5_match_kept", 'hF5, 1);
        check("t5_irq_kept", 32'(timer_irq), 32'h1);
        read_chk("t5_cnt_reload", 'hF2, 0);
        drive('hF2, 1'b0, 0);
        drive('hF2, 1'b1, 'h10);
        for (int k = 0; k <= 4; k++) read_chk("t5_cnt_write", 'hF2, (k < 4) ? 'h10 : 'h11);

        // Wrap without match, then match at zero
        drive('hF3, 1'b1, 0);
        drive('hF5, 1'b1, 1);
        drive('hF4, 1'b1, 0);
        drive('hF2, 1'b1, 'hFE);
        drive('hF3, 1'b1, 1);
        for (int k = 1; k <= 14; k++) begin
            a = (k == 10 || k == 13) ? 'hF5 : 'hF2;
            if (a == 'hF5) e = (k == 13) ? 1 : 0;
            else e = (k <= 4) ? 'hFE : (k <= 8) ? 'hFF : (k <= 12) ? 0 : 1;
            read_chk("t6_wrap", a, e);
        end

        // Reset mid-count
        drive('hF2, 1'b0, 0, 1'b1);
        drive('hF0, 1'b0, 0);
        @(negedge clk);
        check("t6_rst_gpio_out", 32'(gpio_out), 32'h0);
        check("t6_rst_irq", 32'(timer_irq), 32'h0);
        check("t6_rst_rd_gpio", 32'(mem_rdata), 32'h0);
        read_chk("t6_rst_cnt", 'hF2, 0);
        read_chk("t6_rst_ctrl", 'hF3, 0);
        read_chk("t6_rst_cmp", 'hF4, 0);
        read_chk("t6_rst_status", 'hF5, 0);
        read_chk("t6_ram_kept", 'h10, 'h5A);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            int addr;
            int wd;
            r = int'($urandom_range(0, 99));
            if (r < 70) addr = IO_BASE + int'($urandom_range(0, 9));
            else if (r < 75) addr = 'hEF;
            else addr = int'($urandom_range(0, 15));
            wd = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
            drive(addr, ($urandom_range(0, 2) == 0), wd, ($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 9) == 0) gpio_in = DW'($urandom);
        end

        drive(0, 1'b0, 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
